// File: rtl/pic_priority_resolver.sv
// Interrupt request / in-service engine: captures IR0-IR7, resolves rotating priority,
// runs the two-pulse INTA acknowledge and executes EOI / rotate commands.
module pic_priority_resolver #(
  parameter int unsigned NIR = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [NIR-1:0] ir,
  input  logic           ltim,
  input  logic           aeoi,
  input  logic [NIR-1:0] mask,
  input  logic           inta_n,
  input  logic           eoi_stb,
  input  logic           eoi_spec,
  input  logic           eoi_rot,
  input  logic [2:0]     eoi_lvl,
  input  logic           setpri_stb,
  input  logic           aeoi_rot,
  output logic           int_o,
  output logic [NIR-1:0] irr_o,
  output logic [NIR-1:0] isr_o,
  output logic [2:0]     vec_o,
  output logic           vec_vld
);

  typedef enum logic [1:0] {StIdle, StAck1, StAck2} state_e;

  state_e         state_q, state_d;
  logic [NIR-1:0] irr_q, irr_d;
  logic [NIR-1:0] isr_q, isr_d;
  logic [NIR-1:0] ir_prev_q;
  logic [2:0]     lp_q, lp_d;
  logic [2:0]     ack_lvl_q, ack_lvl_d;
  logic           spur_q, spur_d;
  logic           inta_s1_q, inta_s2_q;
  logic           int_q, int_d;
  logic [2:0]     vec_q, vec_d;
  logic           vec_vld_q, vec_vld_d;

  logic [NIR-1:0] req;
  logic [2:0]     lvl;
  logic           cand_found, isr_found;
  logic [2:0]     cand_lvl, cand_rank, isr_lvl, isr_rank;
  logic           valid;
  logic           inta_fall, inta_rise;
  logic [NIR-1:0] ack_set, aeoi_clr, eoi_clr;

  assign req       = irr_q & ~mask;
  assign inta_fall = inta_s2_q & ~inta_s1_q;
  assign inta_rise = ~inta_s2_q & inta_s1_q;

  // Scan levels from lp+1 upward; the first hit in each vector is its highest-priority bit.
  always_comb begin
    cand_found = 1'b0;
    cand_lvl   = '0;
    cand_rank  = '0;
    isr_found  = 1'b0;
    isr_lvl    = '0;
    isr_rank   = '0;
    lvl        = '0;
    for (int unsigned i = 0; i < NIR; i++) begin
      lvl = lp_q + 3'(i + 1);
      if (!cand_found && req[lvl]) begin
        cand_found = 1'b1;
        cand_lvl   = lvl;
        cand_rank  = 3'(i);
      end
      if (!isr_found && isr_q[lvl]) begin
        isr_found = 1'b1;
        isr_lvl   = lvl;
        isr_rank  = 3'(i);
      end
    end
    // Lower rank means higher priority; must strictly beat the highest in-service level.
    valid = cand_found && (!isr_found || (cand_rank < isr_rank));
  end

  // Acknowledge FSM, EOI/rotate commands and next-state of all registers.
  always_comb begin
    state_d   = state_q;
    ack_lvl_d = ack_lvl_q;
    spur_d    = spur_q;
    int_d     = (state_q == StIdle) ? valid : 1'b0;
    vec_d     = vec_q;
    vec_vld_d = 1'b0;
    lp_d      = lp_q;
    ack_set   = '0;
    aeoi_clr  = '0;
    eoi_clr   = '0;

    unique case (state_q)
      StIdle: begin
        if (inta_fall) begin
          if (valid) begin
            ack_lvl_d         = cand_lvl;
            spur_d            = 1'b0;
            ack_set[cand_lvl] = 1'b1;
            int_d             = 1'b0;
          end else begin
            ack_lvl_d = 3'd7;
            spur_d    = 1'b1;
          end
          state_d = StAck1;
        end
      end
      StAck1: begin
        if (inta_fall) begin
          vec_d     = ack_lvl_q;
          vec_vld_d = 1'b1;
          if (aeoi && !spur_q) begin
            aeoi_clr[ack_lvl_q] = 1'b1;
            if (aeoi_rot) lp_d = ack_lvl_q;
          end
          state_d = StAck2;
        end
      end
      StAck2: begin
        if (inta_rise) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (eoi_stb) begin
      if (eoi_spec) begin
        eoi_clr[eoi_lvl] = 1'b1;
        if (eoi_rot) lp_d = eoi_lvl;
      end else if (isr_found) begin
        eoi_clr[isr_lvl] = 1'b1;
        if (eoi_rot) lp_d = isr_lvl;
      end
    end
    // Explicit set-priority overrides any rotate in the same cycle.
    if (setpri_stb) lp_d = eoi_lvl;

    // A set of the same bit beats any clear.
    isr_d = (isr_q & ~eoi_clr & ~aeoi_clr) | ack_set;
    // The acknowledge clear also swallows a coincident new edge.
    if (ltim) irr_d = ir & ~ack_set;
    else      irr_d = ((irr_q | (ir & ~ir_prev_q)) & ir) & ~ack_set;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      irr_q     <= '0;
      isr_q     <= '0;
      ir_prev_q <= '0;
      lp_q      <= 3'd7;
      ack_lvl_q <= '0;
      spur_q    <= 1'b0;
      inta_s1_q <= 1'b1;
      inta_s2_q <= 1'b1;
      int_q     <= 1'b0;
      vec_q     <= '0;
      vec_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      irr_q     <= irr_d;
      isr_q     <= isr_d;
      ir_prev_q <= ir;
      lp_q      <= lp_d;
      ack_lvl_q <= ack_lvl_d;
      spur_q    <= spur_d;
      inta_s1_q <= inta_n;
      inta_s2_q <= inta_s1_q;
      int_q     <= int_d;
      vec_q     <= vec_d;
      vec_vld_q <= vec_vld_d;
    end
  end

  assign int_o   = int_q;
  assign irr_o   = irr_q;
  assign isr_o   = isr_q;
  assign vec_o   = vec_q;
  assign vec_vld = vec_vld_q;

endmodule

// File: tb/tb_pic_priority_resolver.sv
// Directed bench: stimulus pushes expected vectors, a monitor checks every vec_vld pulse.
module tb_pic_priority_resolver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] ir;
  logic       ltim, aeoi, inta_n, eoi_stb, eoi_spec, eoi_rot, setpri_stb, aeoi_rot;
  logic [7:0] mask;
  logic [2:0] eoi_lvl;
  logic       int_o, vec_vld;
  logic [7:0] irr_o, isr_o;
  logic [2:0] vec_o;

  int checks   = 0;
  int failures = 0;
  logic [2:0] exp_q[$];
  logic [2:0] exp_v;

  pic_priority_resolver #(.NIR(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ir         (ir),
    .ltim       (ltim),
    .aeoi       (aeoi),
    .mask       (mask),
    .inta_n     (inta_n),
    .eoi_stb    (eoi_stb),
    .eoi_spec   (eoi_spec),
    .eoi_rot    (eoi_rot),
    .eoi_lvl    (eoi_lvl),
    .setpri_stb (setpri_stb),
    .aeoi_rot   (aeoi_rot),
    .int_o      (int_o),
    .irr_o      (irr_o),
    .isr_o      (isr_o),
    .vec_o      (vec_o),
    .vec_vld    (vec_vld)
  );

  always #5 clk = ~clk;

  // Monitor: every vector-valid pulse must match the oldest expected vector.
  always @(negedge clk) begin
    if (vec_vld === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_vec_vld: got vec_o=%0d, expected no pulse", vec_o);
      end else begin
        exp_v = exp_q.pop_front();
        if (vec_o !== exp_v) begin
          failures++;
          $display("FAIL vec_o: got %0d expected %0d", vec_o, exp_v);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One INTA pulse: 3 clocks low, 3 clocks high.
  task automatic pulse();
    inta_n = 1'b0;
    cyc(3);
    inta_n = 1'b1;
    cyc(3);
  endtask

  task automatic eoi(input logic spec, input logic rot, input logic [2:0] lv);
    eoi_stb  = 1'b1;
    eoi_spec = spec;
    eoi_rot  = rot;
    eoi_lvl  = lv;
    cyc(1);
    eoi_stb  = 1'b0;
    eoi_spec = 1'b0;
    eoi_rot  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; ir = '0; ltim = 1'b0; aeoi = 1'b0; mask = '0; inta_n = 1'b1;
    eoi_stb = 1'b0; eoi_spec = 1'b0; eoi_rot = 1'b0; eoi_lvl = '0;
    setpri_stb = 1'b0; aeoi_rot = 1'b0;
    cyc(3);
    chk("rst_int", {7'd0, int_o}, 8'h00);
    chk("rst_irr", irr_o, 8'h00);
    chk("rst_isr", isr_o, 8'h00);
    chk("rst_vec", {5'd0, vec_o}, 8'h00);
    chk("rst_vld", {7'd0, vec_vld}, 8'h00);
    rst_n = 1'b1;
    cyc(2);

    // Basic edge request on IR3.
    ir = 8'h08;
    cyc(1);
    chk("t1_irr", irr_o, 8'h08);
    chk("t1_int_early", {7'd0, int_o}, 8'h00);
    cyc(1);
    chk("t1_int", {7'd0, int_o}, 8'h01);
    exp_q.push_back(3'd3);
    pulse();
    chk("t1_isr", isr_o, 8'h08);
    chk("t1_irr_ack", irr_o, 8'h00);
    chk("t1_int_ack", {7'd0, int_o}, 8'h00);
    pulse();
    chk("t1_vec", {5'd0, vec_o}, 8'h03);
    ir = 8'h00;
    eoi(1'b0, 1'b0, 3'd0);
    chk("t1_eoi", isr_o, 8'h00);
    cyc(2);

    // Nesting: IR5 in service, IR2 preempts, IR6 must wait.
    ir = 8'h20;
    cyc(2);
    chk("t2_int5", {7'd0, int_o}, 8'h01);
    exp_q.push_back(3'd5);
    pulse();
    chk("t2_isr5", isr_o, 8'h20);
    pulse();
    ir = 8'h24;
    cyc(2);
    chk("t2_int2", {7'd0, int_o}, 8'h01);
    exp_q.push_back(3'd2);
    pulse();
    chk("t2_isr24", isr_o, 8'h24);
    chk("t2_irr", irr_o, 8'h00);
    pulse();
    ir = 8'h64;
    cyc(2);
    chk("t2_irr6", irr_o, 8'h40);
    chk("t2_int6_blk", {7'd0, int_o}, 8'h00);
    eoi(1'b0, 1'b0, 3'd0);
    chk("t2_eoi2", isr_o, 8'h20);
    cyc(2);
    chk("t2_int6_blk5", {7'd0, int_o}, 8'h00);
    eoi(1'b0, 1'b0, 3'd0);
    chk("t2_eoi5", isr_o, 8'h00);
    cyc(2);
    chk("t2_int6", {7'd0, int_o}, 8'h01);
    exp_q.push_back(3'd6);
    pulse();
    pulse();
    eoi(1'b0, 1'b0, 3'd0);
    ir = 8'h00;
    cyc(2);
    chk("t2_isr_end", isr_o, 8'h00);
    chk("t2_int_end", {7'd0, int_o}, 8'h00);

    // Mask: IR0 masked, IR1 served; IR0 raised once unmasked.
    mask = 8'h01;
    ir   = 8'h03;
    cyc(2);
    chk("t3_irr", irr_o, 8'h03);
    chk("t3_int", {7'd0, int_o}, 8'h01);
    exp_q.push_back(3'd1);
    pulse();
    chk("t3_isr", isr_o, 8'h02);
    chk("t3_irr_ack", irr_o, 8'h01);
    pulse();
    eoi(1'b1, 1'b0, 3'd1);
    chk("t3_eoi", isr_o, 8'h00);
    cyc(2);
    chk("t3_int_masked", {7'd0, int_o}, 8'h00);
    mask = 8'h00;
    cyc(2);
    chk("t3_int_unmask", {7'd0, int_o}, 8'h01);
    exp_q.push_back(3'd0);
    pulse();
    pulse();
    chk("t3_isr0", isr_o, 8'h01);
    eoi(1'b0, 1'b0, 3'd0);
    ir = 8'h00;
    cyc(2);

    // AEOI with rotation, level-triggered IR0 and IR7.
    ltim = 1'b1; aeoi = 1'b1; aeoi_rot = 1'b1;
    ir = 8'h81;
    cyc(2);
    chk("t4_irr", irr_o, 8'h81);
    chk("t4_int", {7'd0, int_o}, 8'h01);
    exp_q.push_back(3'd0);
    pulse();
    chk("t4_isr_mid", isr_o, 8'h01);
    pulse();
    chk("t4_isr_aeoi", isr_o, 8'h00);
    cyc(2);
    chk("t4_int_rot", {7'd0, int_o}, 8'h01);
    exp_q.push_back(3'd7);
    pulse();
    pulse();
    chk("t4_isr_end", isr_o, 8'h00);
    ir = 8'h00;
    cyc(2);
    ltim = 1'b0; aeoi = 1'b0; aeoi_rot = 1'b0;
    chk("t4_irr_end", irr_o, 8'h00);
    cyc(2);

    // Spurious: request withdrawn before INTA.
    ir = 8'h10;
    cyc(1);
    ir = 8'h00;
    cyc(3);
    exp_q.push_back(3'd7);
    pulse();
    chk("t5_isr_spur", isr_o, 8'h00);
    pulse();
    chk("t5_vec", {5'd0, vec_o}, 8'h07);
    chk("t5_isr_end", isr_o, 8'h00);

    // Specific EOI on level 4 in the same cycle ISR bit 4 is set.
    ir = 8'h10;
    cyc(2);
    chk("t6_int", {7'd0, int_o}, 8'h01);
    inta_n = 1'b0;
    cyc(1);
    eoi_stb = 1'b1; eoi_spec = 1'b1; eoi_lvl = 3'd4;
    cyc(1);
    eoi_stb = 1'b0; eoi_spec = 1'b0;
    cyc(1);
    inta_n = 1'b1;
    cyc(3);
    chk("t6_isr_wins", isr_o, 8'h10);
    exp_q.push_back(3'd4);
    pulse();
    ir = 8'h00;
    eoi(1'b0, 1'b0, 3'd0);
    chk("t6_isr_end", isr_o, 8'h00);

    // Move lowest priority to 2, then reset mid-acknowledge must restore lp=7.
    eoi_lvl = 3'd2;
    setpri_stb = 1'b1;
    cyc(1);
    setpri_stb = 1'b0;
    ir = 8'h08;
    cyc(2);
    pulse();
    chk("t7_isr_ack1", isr_o, 8'h08);
    rst_n = 1'b0;
    ir = 8'h00;
    cyc(2);
    chk("t7_int", {7'd0, int_o}, 8'h00);
    chk("t7_irr", irr_o, 8'h00);
    chk("t7_isr", isr_o, 8'h00);
    chk("t7_vec", {5'd0, vec_o}, 8'h00);
    chk("t7_vld", {7'd0, vec_vld}, 8'h00);
    rst_n = 1'b1;
    cyc(2);
    ir = 8'h81;
    cyc(2);
    chk("t7_int_post", {7'd0, int_o}, 8'h01);
    exp_q.push_back(3'd0);
    pulse();
    pulse();
    chk("t7_isr_lp7", isr_o, 8'h01);
    eoi(1'b0, 1'b0, 3'd0);
    ir = 8'h00;
    cyc(3);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_vec_vld: got %0d pending, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
